// File: rtl/fifo_read.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_read
//  Purpose  : Read-side controller of an asynchronous FIFO (read clock
//             domain). Issues RAM reads against the synchronised write
//             pointer and presents words on a first-word-fall-through
//             valid/ready port through a two-entry output buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_read #(
  parameter int BIT_SIZE   = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  reset_n,
  input  logic [BIT_SIZE:0]     wptr_sync,
  input  logic [DATA_WIDTH-1:0] rdata_ram,
  input  logic                  dout_ready,
  output logic [BIT_SIZE:0]     rptr,
  output logic [BIT_SIZE-1:0]   raddr,
  output logic                  ren,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic [BIT_SIZE:0]     fifo_occu_out
);

  logic [BIT_SIZE:0]     r_rptr;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  r_skid_valid;
  logic                  r_empty;
  logic [BIT_SIZE:0]     r_occu;

  logic                  w_ram_empty;
  logic                  w_pop;
  logic [1:0]            w_slots;
  logic                  w_ren;

  // Read request: only while unread words exist and the buffer (including
  // the word already in flight) will have room for the returning word.
  always_comb begin
    w_ram_empty = (r_rptr == wptr_sync);
    w_pop       = r_dout_valid & dout_ready;
    w_slots     = {1'b0, r_dout_valid} + {1'b0, r_skid_valid}
                + {1'b0, r_inflight} - {1'b0, w_pop};
    w_ren       = !w_ram_empty && (w_slots < 2'd2);
  end

  // Read pointer, in-flight flag and the lagging status registers.
  always_ff @(posedge rclk) begin
    if (!reset_n) begin
      r_rptr     <= '0;
      r_inflight <= 1'b0;
      r_empty    <= 1'b1;
      r_occu     <= '0;
    end else begin
      r_inflight <= w_ren;
      if (w_ren) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_empty <= w_ram_empty;
      r_occu  <= wptr_sync - r_rptr;
    end
  end

  // Two-entry output buffer: output register in front, skid register behind;
  // returning RAM data goes to the output register whenever it is (or is
  // becoming) free and nothing older waits in the skid register.
  always_ff @(posedge rclk) begin
    if (!reset_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
    end else if (r_inflight) begin
      if (!r_dout_valid || (w_pop && !r_skid_valid)) begin
        r_dout       <= rdata_ram;
        r_dout_valid <= 1'b1;
      end else if (w_pop) begin
        r_dout      <= r_skid_data;
        r_skid_data <= rdata_ram;
      end else begin
        r_skid_data  <= rdata_ram;
        r_skid_valid <= 1'b1;
      end
    end else if (w_pop) begin
      if (r_skid_valid) begin
        r_dout       <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign rptr          = r_rptr;
  assign raddr         = r_rptr[BIT_SIZE-1:0];
  assign ren           = w_ren;
  assign dout          = r_dout;
  assign dout_valid    = r_dout_valid;
  assign empty         = r_empty;
  assign fifo_occu_out = r_occu;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_read
//  Purpose  : Self-checking bench for fifo_read (scoreboard of written words).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read;
  localparam int BSA = 10;
  localparam int BSB = 2;
  localparam int DW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A (full size)
  logic rst_n_a, ready_a, ren_a, dv_a, empty_a;
  logic [BSA:0] wptr_a, rptr_a, occu_a;
  logic [BSA-1:0] raddr_a;
  logic [DW-1:0] rdata_a, dout_a;
  // DUT B (tiny, for wrap-around)
  logic rst_n_b, ready_b, ren_b, dv_b, empty_b;
  logic [BSB:0] wptr_b, rptr_b, occu_b;
  logic [BSB-1:0] raddr_b;
  logic [DW-1:0] rdata_b, dout_b;

  fifo_read #(.BIT_SIZE(BSA), .DATA_WIDTH(DW)) u_a (
    .rclk(clk), .reset_n(rst_n_a), .wptr_sync(wptr_a), .rdata_ram(rdata_a),
    .dout_ready(ready_a), .rptr(rptr_a), .raddr(raddr_a), .ren(ren_a),
    .dout(dout_a), .dout_valid(dv_a), .empty(empty_a), .fifo_occu_out(occu_a));

  fifo_read #(.BIT_SIZE(BSB), .DATA_WIDTH(DW)) u_b (
    .rclk(clk), .reset_n(rst_n_b), .wptr_sync(wptr_b), .rdata_ram(rdata_b),
    .dout_ready(ready_b), .rptr(rptr_b), .raddr(raddr_b), .ren(ren_b),
    .dout(dout_b), .dout_valid(dv_b), .empty(empty_b), .fifo_occu_out(occu_b));

  // RAM models, one-cycle read latency
  logic [DW-1:0] mem_a [2**BSA];
  logic [DW-1:0] mem_b [2**BSB];
  always @(posedge clk) if (ren_a) rdata_a <= mem_a[raddr_a];
  always @(posedge clk) if (ren_b) rdata_b <= mem_b[raddr_b];

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  int wp_a, wp_b, rd_b, cyc;
  int ren_cnt_a, pop_cnt_a, ren_first_a, ren_last_a, pop_first_a, pop_last_a;
  int ren_cnt_b, wraps_b;
  logic [BSA-1:0] last_raddr_a;
  logic stall_a, stall_b, prev_ok_b;
  logic [DW-1:0] hold_a, hold_b;
  logic [BSB:0] pw_b, pr_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observation at the falling edge: inputs and outputs are stable for the
  // coming rising edge, so a visible handshake is a pop at that edge.
  task automatic mon();
    if (rst_n_a) begin
      if (ren_a) begin
        if (ren_first_a < 0) ren_first_a = cyc;
        ren_last_a = cyc;
        ren_cnt_a++;
        last_raddr_a = raddr_a;
      end
      if (stall_a) chk("hold_a", dout_a, hold_a);
      if (dv_a && ready_a) begin
        if (q_a.size() == 0) chk("unexpected_word_a", q_a.size(), 1);
        else begin
          chk("dout_a", dout_a, q_a.pop_front());
          if (pop_first_a < 0) pop_first_a = cyc;
          pop_last_a = cyc;
          pop_cnt_a++;
        end
      end
      chk("buf_ovf_a", (int'(u_a.r_dout_valid) + int'(u_a.r_skid_valid)
                        + int'(u_a.r_inflight)) <= 2, 1);
      stall_a = dv_a && !ready_a;
      hold_a  = dout_a;
    end else stall_a = 1'b0;

    if (rst_n_b) begin
      if (prev_ok_b) begin
        chk("occu_b", occu_b, 32'(3'(pw_b - pr_b)));
        chk("empty_b", empty_b, pw_b == pr_b);
        if (pr_b == 3'd7 && rptr_b == 3'd0) wraps_b++;
      end
      if (ren_b) begin
        chk("raddr_b", raddr_b, rd_b & 3);
        rd_b++;
        ren_cnt_b++;
      end
      if (stall_b) chk("hold_b", dout_b, hold_b);
      if (dv_b && ready_b) begin
        if (q_b.size() == 0) chk("unexpected_word_b", q_b.size(), 1);
        else chk("dout_b", dout_b, q_b.pop_front());
      end
      chk("buf_ovf_b", (int'(u_b.r_dout_valid) + int'(u_b.r_skid_valid)
                        + int'(u_b.r_inflight)) <= 2, 1);
      stall_b = dv_b && !ready_b;
      hold_b  = dout_b;
    end else stall_b = 1'b0;
    prev_ok_b = rst_n_b;
    pw_b = wptr_b;
    pr_b = rptr_b;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_a(input int n);
    logic [DW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = DW'($urandom);
      mem_a[wp_a[BSA-1:0]] = v;
      q_a.push_back(v);
      wp_a++;
    end
    wptr_a = wp_a[BSA:0];
  endtask

  task automatic push_b(input int n);
    logic [DW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = DW'($urandom);
      mem_b[wp_b[BSB-1:0]] = v;
      q_b.push_back(v);
      wp_b++;
    end
    wptr_b = wp_b[BSB:0];
  endtask

  task automatic reset_a(input int n);
    rst_n_a = 1'b0; ready_a = 1'b0; wp_a = 0; wptr_a = '0; q_a.delete();
    repeat (n) tick();
    rst_n_a = 1'b1;
  endtask

  task automatic drain_a(input int budget);
    int k;
    k = 0;
    ready_a = 1'b1;
    while (q_a.size() != 0 && k < budget) begin tick(); k++; end
    chk("drain_a", q_a.size(), 0);
  endtask

  task automatic drain_b(input int budget);
    int k;
    k = 0;
    ready_b = 1'b1;
    while (q_b.size() != 0 && k < budget) begin tick(); k++; end
    chk("drain_b", q_b.size(), 0);
  endtask

  initial begin
    int base_r, base_p, sent, k;
    cyc = 0; wp_a = 0; wp_b = 0; rd_b = 0;
    ren_cnt_a = 0; pop_cnt_a = 0; ren_cnt_b = 0; wraps_b = 0;
    ren_first_a = -1; ren_last_a = -1; pop_first_a = -1; pop_last_a = -1;
    stall_a = 0; stall_b = 0; prev_ok_b = 0; hold_a = '0; hold_b = '0;
    pw_b = '0; pr_b = '0; last_raddr_a = '0;
    rst_n_a = 1'b0; rst_n_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    wptr_b = '0;
    push_a(5);

    // Reset held 3 cycles with words pending
    repeat (3) tick();
    chk("rst_rptr", rptr_a, 0);
    chk("rst_valid", dv_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_occu", occu_a, 0);
    rst_n_a = 1'b1;
    tick();
    chk("rel_rptr", rptr_a, 1);
    chk("rel_valid_early", dv_a, 0);
    tick();
    chk("rel_valid", dv_a, 1);
    chk("rel_first_word", dout_a, q_a[0]);
    drain_a(40);
    repeat (2) tick();
    chk("rel_empty", empty_a, 1);
    chk("rel_occu", occu_a, 0);

    // Single word
    reset_a(2);
    base_r = ren_cnt_a; base_p = pop_cnt_a;
    ready_a = 1'b1;
    push_a(1);
    repeat (6) tick();
    chk("single_ren", ren_cnt_a - base_r, 1);
    chk("single_raddr", last_raddr_a, 0);
    chk("single_pops", pop_cnt_a - base_p, 1);
    chk("single_valid_off", dv_a, 0);
    chk("single_empty", empty_a, 1);
    chk("single_occu", occu_a, 0);
    chk("single_sb", q_a.size(), 0);

    // Burst of 8 with ready held high
    reset_a(2);
    base_r = ren_cnt_a; base_p = pop_cnt_a;
    ren_first_a = -1; pop_first_a = -1;
    ready_a = 1'b1;
    push_a(8);
    repeat (14) tick();
    chk("burst_ren", ren_cnt_a - base_r, 8);
    chk("burst_ren_span", ren_last_a - ren_first_a, 7);
    chk("burst_pops", pop_cnt_a - base_p, 8);
    chk("burst_pop_span", pop_last_a - pop_first_a, 7);
    chk("burst_latency", pop_first_a - ren_first_a, 2);
    chk("burst_rptr", rptr_a, 8);
    chk("burst_sb", q_a.size(), 0);

    // Backpressure: 6 stalled cycles then release
    reset_a(2);
    base_r = ren_cnt_a; base_p = pop_cnt_a;
    push_a(8);
    repeat (6) tick();
    chk("bp_reads", ren_cnt_a - base_r, 2);
    chk("bp_valid", dv_a, 1);
    chk("bp_dout", dout_a, q_a[0]);
    pop_first_a = -1;
    drain_a(30);
    chk("bp_pops", pop_cnt_a - base_p, 8);
    chk("bp_pop_span", pop_last_a - pop_first_a, 7);

    // Reset while a word is held and another read is in flight
    reset_a(2);
    push_a(8);
    tick(); tick();
    chk("mid_state", {u_a.r_dout_valid, u_a.r_inflight}, 2'b11);
    rst_n_a = 1'b0; wp_a = 0; wptr_a = '0; q_a.delete(); ready_a = 1'b1;
    tick();
    chk("mid_valid", dv_a, 0);
    rst_n_a = 1'b1;
    repeat (5) tick();
    chk("mid_valid_after", dv_a, 0);
    chk("mid_rptr", rptr_a, 0);

    // Wrap-around on the small instance with random ready
    repeat (2) tick();
    rst_n_b = 1'b1;
    sent = 0; k = 0;
    while ((sent < 20 || q_b.size() != 0) && k < 400) begin
      ready_b = 1'($urandom_range(0, 1));
      if (sent < 20 && 3'(wp_b[BSB:0] - rptr_b) < 3'd4) begin
        push_b(1);
        sent++;
      end
      tick();
      k++;
    end
    chk("wrap_sb", q_b.size(), 0);
    chk("wrap_reads", ren_cnt_b, 20);
    chk("wrap_rptr", rptr_b, 4);
    chk("wrap_seen", wraps_b >= 1, 1);
    // Occupancy across the wrap: wptr 1, rptr 6 -> 3
    ready_b = 1'b0;
    push_b(2);
    repeat (6) tick();
    chk("occw_rptr", rptr_b, 6);
    push_b(3);
    tick(); tick();
    chk("occw_wptr", wptr_b, 1);
    chk("occw_occu", occu_b, 3);
    chk("occw_empty", empty_b, 0);
    drain_b(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
